kws_param_loader: RTL and testbench
===================================

Name: kws_param_loader

Overview:
- Configuration sequencer for the CNN keyword-spotting datapath (conv1, conv2, fc1, fc2).
- Accepts one byte stream of parameter segments over a valid/ready handshake and writes each byte into per-layer parameter storage through a single addressed write port.
- After each segment it issues the matching per-layer load strobe and tracks which segments are loaded.
- Sits between the host/DMA parameter source and the layer weight/bias inputs. Asserts params_ready once all eight segments are loaded.

Parameters:
ACTIV_BITS, 8, byte width of stream and write data; must be 8
ADDR_W, 16, write address width; must cover the largest segment
CONV1_W_LEN, 72, conv1 weight bytes (8 filters x 3x3)
CONV1_B_LEN, 8, conv1 bias bytes
CONV2_W_LEN, 72, conv2 weight bytes
CONV2_B_LEN, 8, conv2 bias bytes
FC1_W_LEN, 40960, fc1 weight bytes (64x640)
FC1_B_LEN, 64, fc1 bias bytes
FC2_W_LEN, 640, fc2 weight bytes (10x64)
FC2_B_LEN, 10, fc2 bias bytes

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
s_data  in  ACTIV_BITS  parameter stream byte
s_valid  in  1  stream byte valid
s_ready  out  1  loader accepts byte; transfer occurs when s_valid&s_ready
clear  in  1  synchronous abort; clears loaded mask and error
wr_en  out  1  parameter write strobe
wr_layer  out  2  0=conv1 1=conv2 2=fc1 3=fc2
wr_kind  out  1  0=weights 1=biases
wr_addr  out  ADDR_W  byte index within segment
wr_data  out  ACTIV_BITS  byte to write
load_weights  out  4  one-hot per-layer weight load pulse (bit = layer id)
load_biases  out  4  one-hot per-layer bias load pulse
loaded  out  8  sticky mask; bit {layer,kind} set when segment completes
params_ready  out  1  loaded == 8'hFF
err  out  1  sticky malformed-header flag

Behaviour:
- Reset: state HDR; s_ready=0 during reset then 1; wr_en=0, wr_layer=0, wr_kind=0, wr_addr=0, wr_data=0; load_weights=load_biases=0; loaded=0; params_ready=0; err=0.
- Segment format: header byte, then exactly LEN(layer,kind) payload bytes. Header bits: [7:3] must be 0, [2:1] layer, [0] kind.
- States:
  - HDR: s_ready=1. On a valid header: latch layer/kind, load the LEN counter, go to PAYLOAD. If any of bits [7:3] is set: go to ERROR; nothing is written.
  - PAYLOAD: s_ready=1. Each accepted byte at cycle t gives wr_en=1 during t+1, with wr_addr = index (0..LEN-1) and wr_data = byte. Idle cycles are allowed when s_valid=0. The last byte moves to FLUSH.
  - FLUSH: one cycle, s_ready=0; the last wr_en is visible here.
  - STROBE: one cycle, s_ready=0. The pulse bit for the latched layer (load_weights or load_biases) is 1. loaded bit {layer,kind} is set (readable t+3). Then return to HDR.
  - ERROR: s_ready=0; bytes are not consumed; err=1. Exit only via clear or rst.
- Latency: header byte to first write needs no extra cycle. Last payload byte at cycle t: wr_en at t+1, load pulse at t+2, s_ready=1 again at t+3.
- Reloading an already-loaded segment is allowed: rewrite, pulse again; the loaded bit stays 1.
- clear: priority over the handshake. s_ready=0 while clear=1. Next state is HDR, loaded=0, err=0, and any wr_en/pulse in flight is suppressed. A partial segment is abandoned with no strobe.
- rst mid-segment: same as clear, plus all outputs return to their reset values.
- Counter: ADDR_W bits, compared against LEN-1; no wrap. All LEN values must be >0 and <2^ADDR_W, checked by an elaboration-time assertion.
- wr_layer/wr_kind/wr_addr/wr_data hold their last value when wr_en=0.

Decomposition:
- Shared package kws_pkg:
  - layer id constants (LAYER_CONV1..LAYER_FC2);
  - kind constants (KIND_W, KIND_B);
  - a segment-length lookup function from (layer,kind) to length, built from the LEN parameters;
  - the state enum (HDR, PAYLOAD, FLUSH, STROBE, ERROR).
- No sub-module: a single FSM plus a counter and registers.

Test Plan:
- Header 8'h00 + 72 bytes 0..71 -> wr_en 72 cycles, wr_layer=0, wr_kind=0, addr 0..71 = data. load_weights=4'b0001 exactly one cycle, 2 cycles after the last byte. loaded=8'h01.
- All 8 segments in order (headers 00..07), random s_valid gaps -> each write count matches its LEN, 8 single pulses, params_ready=1 after the fc2 bias strobe, fc1 addr reaches 40959.
- Header 8'h09 -> err=1, s_ready=0, no wr_en. Then clear for 1 cycle -> err=0, loaded=0, s_ready=1, and header 8'h03 loads conv2 biases (8 bytes, load_biases=4'b0010).
- clear after 5 of 64 fc1 bias bytes -> no load pulse, loaded bit 5 stays 0. A fresh header 8'h05 + 64 bytes completes normally with addresses restarting at 0.
- rst asserted mid conv1 weight payload -> all outputs at reset values the next cycle, and the stream resumes with a header.
- Reload of conv1 bias (8'h01 twice) -> two pulses, loaded bit 1 stays 1. s_ready=0 in the FLUSH/STROBE cycles, and a byte held valid there is accepted at t+3.

Source files
------------

// File: rtl/kws_param_loader_pkg.sv
// kws_pkg: shared constants, types and helpers for the keyword-spotting
// parameter loader.
//   - stream/write widths and the eight segment lengths
//   - layer and kind ids, the write-beat payload struct, the FSM state enum
//   - seg_len(): (layer, kind) -> payload length in bytes
package kws_pkg;

  localparam int unsigned ACTIV_BITS  = 8;
  localparam int unsigned ADDR_W      = 16;

  localparam int unsigned CONV1_W_LEN = 72;
  localparam int unsigned CONV1_B_LEN = 8;
  localparam int unsigned CONV2_W_LEN = 72;
  localparam int unsigned CONV2_B_LEN = 8;
  localparam int unsigned FC1_W_LEN   = 40960;
  localparam int unsigned FC1_B_LEN   = 64;
  localparam int unsigned FC2_W_LEN   = 640;
  localparam int unsigned FC2_B_LEN   = 10;

  localparam logic [1:0] LAYER_CONV1 = 2'd0;
  localparam logic [1:0] LAYER_CONV2 = 2'd1;
  localparam logic [1:0] LAYER_FC1   = 2'd2;
  localparam logic [1:0] LAYER_FC2   = 2'd3;

  localparam logic KIND_W = 1'b0;
  localparam logic KIND_B = 1'b1;

  typedef enum logic [2:0] {
    HDR     = 3'd0,
    PAYLOAD = 3'd1,
    FLUSH   = 3'd2,
    STROBE  = 3'd3,
    ERROR   = 3'd4
  } state_e;

  // One write to the per-layer parameter storage.
  typedef struct packed {
    logic [1:0]            layer;
    logic                  kind;
    logic [ADDR_W-1:0]     addr;
    logic [ACTIV_BITS-1:0] data;
  } wr_beat_t;

  function automatic logic [ADDR_W-1:0] seg_len(input logic [1:0] layer,
                                                 input logic       kind);
    logic [ADDR_W-1:0] len;
    case ({layer, kind})
      {LAYER_CONV1, KIND_W}: len = ADDR_W'(CONV1_W_LEN);
      {LAYER_CONV1, KIND_B}: len = ADDR_W'(CONV1_B_LEN);
      {LAYER_CONV2, KIND_W}: len = ADDR_W'(CONV2_W_LEN);
      {LAYER_CONV2, KIND_B}: len = ADDR_W'(CONV2_B_LEN);
      {LAYER_FC1,   KIND_W}: len = ADDR_W'(FC1_W_LEN);
      {LAYER_FC1,   KIND_B}: len = ADDR_W'(FC1_B_LEN);
      {LAYER_FC2,   KIND_W}: len = ADDR_W'(FC2_W_LEN);
      default:               len = ADDR_W'(FC2_B_LEN);
    endcase
    return len;
  endfunction

  // A length must be non-zero and its last index must fit the address counter.
  function automatic bit len_fits(input int unsigned len);
    return (len > 0) && (64'(len) < (64'(1) << ADDR_W));
  endfunction

  function automatic bit lens_valid();
    return (ACTIV_BITS == 8) &&
           len_fits(CONV1_W_LEN) && len_fits(CONV1_B_LEN) &&
           len_fits(CONV2_W_LEN) && len_fits(CONV2_B_LEN) &&
           len_fits(FC1_W_LEN)   && len_fits(FC1_B_LEN)   &&
           len_fits(FC2_W_LEN)   && len_fits(FC2_B_LEN);
  endfunction

endpackage

// File: rtl/kws_param_loader_if.sv
// Parameter byte stream (valid/ready).
//   master: source side (drives s_data/s_valid, sees s_ready)
//   slave : loader side (sees s_data/s_valid, drives s_ready)
interface kws_param_loader_if;
  import kws_pkg::*;

  logic [ACTIV_BITS-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/kws_param_loader.sv
// kws_param_loader: splits a parameter byte stream into header-tagged
// segments, writes each payload byte to per-layer storage and pulses the
// matching per-layer load strobe when a segment completes.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s                   parameter byte stream (slave)
//   clear               synchronous abort, clears loaded mask and err
//   wr_en/layer/kind/addr/data   registered storage write port
//   load_weights/load_biases     one-hot per-layer load pulses
//   loaded, params_ready, err    sticky status
module kws_param_loader
  import kws_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  kws_param_loader_if.slave     s,
  input  logic                  clear,
  output logic                  wr_en,
  output logic [1:0]            wr_layer,
  output logic                  wr_kind,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [ACTIV_BITS-1:0] wr_data,
  output logic [3:0]            load_weights,
  output logic [3:0]            load_biases,
  output logic [7:0]            loaded,
  output logic                  params_ready,
  output logic                  err
);

  if (!lens_valid()) begin : g_bad_cfg
    $error("kws_param_loader: segment length zero or beyond ADDR_W, or ACTIV_BITS != 8");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        layer_q, layer_d;
  logic              kind_q, kind_d;
  wr_beat_t          beat_q, beat_d;
  logic              wr_en_q, wr_en_d;
  logic [3:0]        ldw_q, ldw_d;
  logic [3:0]        ldb_q, ldb_d;
  logic [7:0]        loaded_q, loaded_d;
  logic              ready_q;
  logic              err_q, err_d;

  logic accept;
  logic hdr_ok;
  logic last_byte;

  // clear and rst gate the handshake immediately so nothing is consumed.
  assign s.s_ready = ((state_q == HDR) || (state_q == PAYLOAD)) && !clear && !rst;
  assign accept    = s.s_valid && s.s_ready;
  assign hdr_ok    = (s.s_data[7:3] == 5'd0);
  assign last_byte = (cnt_q == (seg_len(layer_q, kind_q) - ADDR_W'(1)));

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    layer_d  = layer_q;
    kind_d   = kind_q;
    beat_d   = beat_q;
    wr_en_d  = 1'b0;
    ldw_d    = 4'b0;
    ldb_d    = 4'b0;
    loaded_d = loaded_q;
    err_d    = err_q;

    if (clear) begin
      // Abort: in-flight write/pulse is dropped by the zero defaults above.
      state_d  = HDR;
      cnt_d    = '0;
      loaded_d = 8'h00;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        HDR: begin
          if (accept) begin
            if (hdr_ok) begin
              layer_d = s.s_data[2:1];
              kind_d  = s.s_data[0];
              cnt_d   = '0;
              state_d = PAYLOAD;
            end else begin
              err_d   = 1'b1;
              state_d = ERROR;
            end
          end
        end
        PAYLOAD: begin
          if (accept) begin
            wr_en_d = 1'b1;
            beat_d  = '{layer: layer_q, kind: kind_q, addr: cnt_q, data: s.s_data};
            if (last_byte) state_d = FLUSH;
            else           cnt_d   = cnt_q + ADDR_W'(1);
          end
        end
        FLUSH: begin
          if (kind_q == KIND_W) ldw_d[layer_q] = 1'b1;
          else                  ldb_d[layer_q] = 1'b1;
          state_d = STROBE;
        end
        STROBE: begin
          loaded_d[{layer_q, kind_q}] = 1'b1;
          state_d = HDR;
        end
        ERROR:   state_d = ERROR;
        default: state_d = HDR;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HDR;
      cnt_q    <= '0;
      layer_q  <= '0;
      kind_q   <= 1'b0;
      beat_q   <= '0;
      wr_en_q  <= 1'b0;
      ldw_q    <= 4'b0;
      ldb_q    <= 4'b0;
      loaded_q <= 8'h00;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      layer_q  <= layer_d;
      kind_q   <= kind_d;
      beat_q   <= beat_d;
      wr_en_q  <= wr_en_d;
      ldw_q    <= ldw_d;
      ldb_q    <= ldb_d;
      loaded_q <= loaded_d;
      ready_q  <= &loaded_d;
      err_q    <= err_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_layer     = beat_q.layer;
  assign wr_kind      = beat_q.kind;
  assign wr_addr      = beat_q.addr;
  assign wr_data      = beat_q.data;
  assign load_weights = ldw_q;
  assign load_biases  = ldb_q;
  assign loaded       = loaded_q;
  assign params_ready = ready_q;
  assign err          = err_q;

endmodule

// File: tb/tb_kws_param_loader.sv
// Bench for kws_param_loader: random payload bytes and random stream gaps,
// checked against a segment-level model (length table, expected-write queue
// with due cycles, loaded mask).
module tb_kws_param_loader;
  import kws_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  clear;
  logic                  wr_en;
  logic [1:0]            wr_layer;
  logic                  wr_kind;
  logic [ADDR_W-1:0]     wr_addr;
  logic [ACTIV_BITS-1:0] wr_data;
  logic [3:0]            load_weights;
  logic [3:0]            load_biases;
  logic [7:0]            loaded;
  logic                  params_ready;
  logic                  err;

  kws_param_loader_if sif ();

  kws_param_loader dut (
    .clk          (clk),
    .rst          (rst),
    .s            (sif),
    .clear        (clear),
    .wr_en        (wr_en),
    .wr_layer     (wr_layer),
    .wr_kind      (wr_kind),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .load_weights (load_weights),
    .load_biases  (load_biases),
    .loaded       (loaded),
    .params_ready (params_ready),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    int unsigned layer;
    int unsigned kind;
    int unsigned addr;
    int unsigned data;
  } exp_wr_t;

  exp_wr_t     exp_q[$];
  int unsigned seg_lens [8] = '{72, 8, 72, 8, 40960, 64, 640, 10};
  int          vec = 0;
  int          bad = 0;
  int unsigned cyc_cnt = 0;
  int unsigned wr_seen = 0;
  int unsigned pulse_cnt = 0;
  int unsigned gap_pct = 0;
  logic [7:0]  exp_loaded = 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vec++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock, sample just after the edge and check the write port.
  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
    if ((load_weights | load_biases) != 4'b0) pulse_cnt++;
    if (wr_en === 1'b1) wr_seen++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc_cnt) begin
      chk("wr_en",    64'(wr_en),    64'd1);
      chk("wr_layer", 64'(wr_layer), 64'(exp_q[0].layer));
      chk("wr_kind",  64'(wr_kind),  64'(exp_q[0].kind));
      chk("wr_addr",  64'(wr_addr),  64'(exp_q[0].addr));
      chk("wr_data",  64'(wr_data),  64'(exp_q[0].data));
      void'(exp_q.pop_front());
    end else begin
      chk("wr_idle", 64'(wr_en), 64'd0);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit payload,
                           input int unsigned layer, input int unsigned kind,
                           input int unsigned addr);
    if (payload && gap_pct != 0 && $urandom_range(99) < gap_pct) begin
      sif.s_valid = 1'b0;
      repeat ($urandom_range(3, 1)) cyc();
    end
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    #1;
    chk("s_ready", 64'(sif.s_ready), 64'd1);
    if (payload) exp_q.push_back('{cyc_cnt + 1, layer, kind, addr, 32'(d)});
    cyc();
    sif.s_valid = 1'b0;
  endtask

  // Whole segment; optionally hold the next byte valid across FLUSH/STROBE.
  task automatic send_seg(input logic [7:0] h, input bit hold, input logic [7:0] nxt);
    int unsigned id, len, w0, p0;
    logic [3:0]  exp_lw, exp_lb;
    id  = 32'(h[2:0]);
    len = seg_lens[id];
    w0  = wr_seen;
    p0  = pulse_cnt;
    send_byte(h, 1'b0, 0, 0, 0);
    for (int unsigned i = 0; i < len; i++)
      send_byte(8'($urandom), 1'b1, 32'(h[2:1]), 32'(h[0]), i);
    sif.s_valid = hold;
    sif.s_data  = nxt;
    #1;
    chk("flush_s_ready", 64'(sif.s_ready), 64'd0);
    chk("flush_pulse",   64'({load_weights, load_biases}), 64'd0);
    exp_lw = 4'b0;
    exp_lb = 4'b0;
    if (h[0]) exp_lb[h[2:1]] = 1'b1;
    else      exp_lw[h[2:1]] = 1'b1;
    cyc();
    chk("strobe_s_ready", 64'(sif.s_ready),    64'd0);
    chk("load_weights",   64'(load_weights),   64'(exp_lw));
    chk("load_biases",    64'(load_biases),    64'(exp_lb));
    chk("loaded_pre",     64'(loaded),         64'(exp_loaded));
    exp_loaded[id[2:0]] = 1'b1;
    cyc();
    chk("loaded",       64'(loaded),       64'(exp_loaded));
    chk("params_ready", 64'(params_ready), 64'(exp_loaded == 8'hFF));
    chk("hdr_s_ready",  64'(sif.s_ready),  64'd1);
    chk("pulse_after",  64'({load_weights, load_biases}), 64'd0);
    chk("wr_count",     64'(wr_seen - w0),   64'(len));
    chk("pulse_count",  64'(pulse_cnt - p0), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"},  64'(wr_en),        64'd0);
    chk({tag, "_layer"},  64'(wr_layer),     64'd0);
    chk({tag, "_kind"},   64'(wr_kind),      64'd0);
    chk({tag, "_addr"},   64'(wr_addr),      64'd0);
    chk({tag, "_data"},   64'(wr_data),      64'd0);
    chk({tag, "_loads"},  64'({load_weights, load_biases}), 64'd0);
    chk({tag, "_loaded"}, 64'(loaded),       64'd0);
    chk({tag, "_pready"}, 64'(params_ready), 64'd0);
    chk({tag, "_err"},    64'(err),          64'd0);
    chk({tag, "_ready"},  64'(sif.s_ready),  64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned p0;
    rst         = 1'b1;
    clear       = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data  = 8'h00;

    // Reset state.
    repeat (2) cyc();
    chk_reset_outputs("reset");
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 64'(sif.s_ready), 64'd1);

    // conv1 weights, no gaps.
    send_seg(8'h00, 1'b0, 8'h00);

    // All eight segments with random gaps.
    gap_pct = 5;
    for (int unsigned i = 0; i < 8; i++) send_seg(8'(i), 1'b0, 8'h00);
    gap_pct = 0;

    // Malformed header -> sticky err, stream stalled, nothing written.
    send_byte(8'h09, 1'b0, 0, 0, 0);
    chk("err_set",   64'(err),           64'd1);
    chk("err_ready", 64'(sif.s_ready),   64'd0);
    sif.s_valid = 1'b1;
    sif.s_data  = 8'($urandom);
    repeat (3) begin
      cyc();
      chk("err_hold_ready", 64'(sif.s_ready), 64'd0);
      chk("err_hold",       64'(err),         64'd1);
    end
    clear = 1'b1;
    #1;
    chk("clear_ready", 64'(sif.s_ready), 64'd0);
    cyc();
    clear       = 1'b0;
    sif.s_valid = 1'b0;
    exp_loaded  = 8'h00;
    chk("clear_err",    64'(err),    64'd0);
    chk("clear_loaded", 64'(loaded), 64'd0);
    #1;
    chk("clear_ready_after", 64'(sif.s_ready), 64'd1);
    send_seg(8'h03, 1'b0, 8'h00);

    // Abandon fc1 biases after 5 bytes, then reload them cleanly.
    p0 = pulse_cnt;
    send_byte(8'h05, 1'b0, 0, 0, 0);
    for (int unsigned i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1, 2, 1, i);
    clear       = 1'b1;
    sif.s_valid = 1'b1;
    sif.s_data  = 8'hAA;
    #1;
    chk("abort_ready", 64'(sif.s_ready), 64'd0);
    cyc();
    clear       = 1'b0;
    sif.s_valid = 1'b0;
    exp_loaded  = 8'h00;
    repeat (3) cyc();
    chk("abort_no_pulse", 64'(pulse_cnt - p0), 64'd0);
    chk("abort_loaded",   64'(loaded),         64'd0);
    send_seg(8'h05, 1'b0, 8'h00);

    // rst in the middle of conv1 weights.
    send_byte(8'h00, 1'b0, 0, 0, 0);
    for (int unsigned i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1, 0, 0, i);
    rst = 1'b1;
    #1;
    chk("rst_ready", 64'(sif.s_ready), 64'd0);
    cyc();
    chk_reset_outputs("midrst");
    rst        = 1'b0;
    exp_loaded = 8'h00;
    chk("midrst_queue", 64'(exp_q.size()), 64'd0);
    send_seg(8'h00, 1'b0, 8'h00);

    // conv1 bias twice; second header held valid through FLUSH/STROBE.
    p0 = pulse_cnt;
    send_seg(8'h01, 1'b1, 8'h01);
    send_seg(8'h01, 1'b0, 8'h00);
    chk("reload_pulses", 64'(pulse_cnt - p0), 64'd2);
    chk("reload_loaded", 64'(loaded),         64'h03);
    chk("final_queue",   64'(exp_q.size()),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
